// File: rtl/lstm_gate_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lstm_gate_gen
//  Description : Sequential LSTM gate pre-activation generator. Latches x and
//                h_prev, streams bias/weights from an external memory through
//                one MAC per cycle, and presents the packed f,g,i,o gate
//                vector behind a valid/ready handshake.
//  Options     : LSTM_GATE_SAT_EN - saturating product and accumulate
//                (undefined: truncate product, accumulator wraps mod 2^32).
//  Revision    : 1.0 - initial release
// ============================================================================
module lstm_gate_gen #(
    parameter int N_IN  = 100,
    parameter int N_HID = 100,
    parameter int FRAC  = 16,
    parameter int AW    = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    input  logic signed [31:0] x_in     [0:N_IN-1],
    input  logic signed [31:0] h_prev   [0:N_HID-1],
    output logic               w_en,
    output logic [AW-1:0]      w_addr,
    input  logic signed [31:0] w_rdata,
    output logic signed [31:0] gate_out [0:4*N_HID-1],
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int c_rows   = 4 * N_HID;
    localparam int c_stride = N_IN + N_HID + 1;
    localparam int c_nvec   = N_IN + N_HID;
    localparam int c_rw     = (c_rows > 1) ? $clog2(c_rows) : 1;
    localparam int c_cw     = $clog2(c_stride);
    localparam int c_vw     = (c_nvec > 1) ? $clog2(c_nvec) : 1;

    localparam logic [c_rw-1:0] c_last_row = c_rw'(c_rows - 1);
    localparam logic [c_cw-1:0] c_last_col = c_cw'(c_stride - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // issue-side counters (address currently driven)
    logic [c_rw-1:0] r_row;
    logic [c_cw-1:0] r_col;
    logic [AW-1:0]   r_addr;
    logic            w_last_issue;

    // return-side tags: which (row, col) the current w_rdata belongs to
    logic            r_rd_vld;
    logic [c_rw-1:0] r_rd_row;
    logic [c_cw-1:0] r_rd_col;

    logic signed [31:0] r_vec  [0:c_nvec-1];
    logic signed [31:0] r_gate [0:c_rows-1];
    logic signed [31:0] r_acc;

    logic [c_vw-1:0]    w_vidx;
    logic signed [31:0] w_opnd;
    logic signed [63:0] w_prod;
    logic signed [63:0] w_shift;
    logic signed [31:0] w_term;
    logic signed [31:0] w_sum;
    logic signed [31:0] w_acc_nxt;

    assign w_last_issue = (r_row == c_last_row) && (r_col == c_last_col);
    assign w_addr       = r_addr;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        w_en        = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                w_en = 1'b1;
                if (w_last_issue) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy        = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // row/column/address walk, one word per cycle while in RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row  <= '0;
            r_col  <= '0;
            r_addr <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_row  <= '0;
            r_col  <= '0;
            r_addr <= '0;
        end else if ((r_state == S_RUN) && !w_last_issue) begin
            r_addr <= r_addr + AW'(1);
            if (r_col == c_last_col) begin
                r_col <= '0;
                r_row <= r_row + c_rw'(1);
            end else begin
                r_col <= r_col + c_cw'(1);
            end
        end
    end

    // tag the read in flight so the returning word knows its row/column
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld <= 1'b0;
            r_rd_row <= '0;
            r_rd_col <= '0;
        end else begin
            r_rd_vld <= w_en;
            r_rd_row <= r_row;
            r_rd_col <= r_col;
        end
    end

    // operand vector v = {x, h_prev}, captured once on the start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_nvec; i++) begin
                r_vec[i] <= '0;
            end
        end else if ((r_state == S_IDLE) && start) begin
            for (int i = 0; i < N_IN; i++) begin
                r_vec[i] <= x_in[i];
            end
            for (int j = 0; j < N_HID; j++) begin
                r_vec[N_IN + j] <= h_prev[j];
            end
        end
    end

    // column k>=1 multiplies v[k-1]; column 0 (bias) never uses the operand
    assign w_vidx  = (r_rd_col == '0) ? '0 : c_vw'(r_rd_col - c_cw'(1));
    assign w_opnd  = r_vec[w_vidx];
    assign w_prod  = $signed({{32{w_rdata[31]}}, w_rdata}) *
                     $signed({{32{w_opnd[31]}}, w_opnd});
    assign w_shift = w_prod >>> FRAC;

`ifdef LSTM_GATE_SAT_EN
    logic signed [32:0] w_sum33;

    // clamp the scaled product, then saturate the running sum
    always_comb begin
        if (w_shift > 64'sh0000_0000_7FFF_FFFF) begin
            w_term = 32'sh7FFF_FFFF;
        end else if (w_shift < -64'sh0000_0000_8000_0000) begin
            w_term = 32'sh8000_0000;
        end else begin
            w_term = w_shift[31:0];
        end
        w_sum33 = {r_acc[31], r_acc} + {w_term[31], w_term};
        if (w_sum33[32] != w_sum33[31]) begin
            w_sum = w_sum33[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        end else begin
            w_sum = w_sum33[31:0];
        end
    end
`else
    logic w_unused_bits;

    // truncate the scaled product and let the accumulator wrap
    always_comb begin
        w_term = w_shift[31:0];
        w_sum  = r_acc + w_term;
    end

    assign w_unused_bits = ^w_shift[63:32];
`endif

    assign w_acc_nxt = (r_rd_col == '0) ? w_rdata : w_sum;

    // accumulate each returned word; commit the row on its last column
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            for (int i = 0; i < c_rows; i++) begin
                r_gate[i] <= '0;
            end
        end else if (r_rd_vld) begin
            r_acc <= w_acc_nxt;
            if (r_rd_col == c_last_col) begin
                r_gate[r_rd_row] <= w_acc_nxt;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < c_rows; gi++) begin : g_gate_out
            assign gate_out[gi] = r_gate[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_lstm_gate_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lstm_gate_gen
//  Description : Self-checking bench for lstm_gate_gen (N_IN=1, N_HID=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lstm_gate_gen;

    localparam int NI     = 1;
    localparam int NH     = 2;
    localparam int ROWS   = 4 * NH;
    localparam int STRIDE = NI + NH + 1;
    localparam int RS     = ROWS * STRIDE;
    localparam int AW     = 6;
    localparam int FR     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic out_ready = 1'b0;
    logic signed [31:0] x_in     [0:NI-1];
    logic signed [31:0] h_prev   [0:NH-1];
    logic               busy;
    logic               w_en;
    logic               out_valid;
    logic [AW-1:0]      w_addr;
    logic signed [31:0] w_rdata;
    logic signed [31:0] gate_out [0:ROWS-1];

    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] vnow [0:NI+NH-1];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    lstm_gate_gen #(.N_IN(NI), .N_HID(NH), .FRAC(FR), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .x_in(x_in), .h_prev(h_prev), .w_en(w_en), .w_addr(w_addr),
        .w_rdata(w_rdata), .gate_out(gate_out), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // weight memory with one-cycle read latency
    always @(posedge clk) begin
        if (w_en) w_rdata <= mem[w_addr];
    end

    always_comb begin
        for (int i = 0; i < NI; i++) vnow[i] = x_in[i];
        for (int j = 0; j < NH; j++) vnow[NI+j] = h_prev[j];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // plain-arithmetic gate value for one row from current memory and vnow
    function automatic logic [31:0] model_row(input int r);
        longint acc;
        longint p;
        acc = longint'($signed(mem[r*STRIDE]));
        for (int k = 1; k < STRIDE; k++) begin
            p = longint'($signed(mem[r*STRIDE+k])) * longint'($signed(vnow[k-1]));
            p = p >>> FR;
`ifdef LSTM_GATE_SAT_EN
            if (p > 64'sd2147483647) p = 64'sd2147483647;
            if (p < -64'sd2147483648) p = -64'sd2147483648;
            acc = acc + p;
            if (acc > 64'sd2147483647) acc = 64'sd2147483647;
            if (acc < -64'sd2147483648) acc = -64'sd2147483648;
`else
            p   = longint'($signed(p[31:0]));
            acc = acc + p;
            acc = longint'($signed(acc[31:0]));
`endif
        end
        return acc[31:0];
    endfunction

    // transaction-level model: 0 idle, 1 computing (m_t = cycle index), 2 done
    int          m_state = 0;
    int          m_t     = 0;
    logic [31:0] m_gate [0:ROWS-1];
    logic [31:0] m_pend [0:ROWS-1];

    always @(posedge clk) begin
        if (rst) begin
            m_state <= 0;
            m_t     <= 0;
            for (int i = 0; i < ROWS; i++) m_gate[i] <= '0;
        end else begin
            case (m_state)
                0: if (start) begin
                    m_state <= 1;
                    m_t     <= 1;
                    for (int i = 0; i < ROWS; i++) m_pend[i] <= model_row(i);
                end
                1: if (m_t == RS + 1) begin
                    m_state <= 2;
                    for (int i = 0; i < ROWS; i++) m_gate[i] <= m_pend[i];
                end else begin
                    m_t <= m_t + 1;
                end
                default: if (out_ready) m_state <= 0;
            endcase
        end
    end

    // cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, (m_state == 1) ? 32'd1 : 32'd0);
            chk("w_en", w_en, (m_state == 1 && m_t <= RS) ? 32'd1 : 32'd0);
            chk("out_valid", out_valid, (m_state == 2) ? 32'd1 : 32'd0);
            if (m_state == 1 && m_t <= RS) chk("w_addr", w_addr, 32'(m_t - 1));
            if (m_state != 1) begin
                for (int i = 0; i < ROWS; i++)
                    chk($sformatf("gate_out[%0d]", i), gate_out[i], m_gate[i]);
            end
        end
    end

    task automatic load_mem(input logic [31:0] b, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
        for (int r = 0; r < ROWS; r++) begin
            mem[r*STRIDE]   = b;
            mem[r*STRIDE+1] = w1;
            mem[r*STRIDE+2] = w2;
            mem[r*STRIDE+3] = w3;
        end
    endtask

    task automatic set_vec(input logic [31:0] x, input logic [31:0] h0, input logic [31:0] h1);
        x_in[0]   = x;
        h_prev[0] = h0;
        h_prev[1] = h1;
    endtask

    // start, wait for out_valid (bounded), hold, handshake
    task automatic run_op(input string tag, input logic [31:0] exp_val,
                          input int hold, input bit scramble);
        int n;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        if (scramble) set_vec(32'h1234_5678, 32'h8765_4321, 32'h0F0F_0F0F);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 32'd33);
        for (int i = 0; i < ROWS; i++) begin
            chk($sformatf("%s_gate[%0d]", tag, i), gate_out[i], exp_val);
            chk($sformatf("%s_model[%0d]", tag, i), m_gate[i], exp_val);
        end
        for (int c = 0; c < hold; c++) begin
            start = (c == 4);
            @(negedge clk);
            chk({tag, "_held_valid"}, out_valid, 32'd1);
            chk({tag, "_held_gate0"}, gate_out[0], exp_val);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, out_valid, 32'd0);
        @(negedge clk);
        chk({tag, "_idle_busy"}, busy, 32'd0);
    endtask

    initial begin
        logic [31:0] ovf_exp;
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
        set_vec(32'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 32'd0);
        chk("rst_w_en", w_en, 32'd0);
        chk("rst_w_addr", w_addr, 32'd0);
        chk("rst_out_valid", out_valid, 32'd0);
        for (int i = 0; i < ROWS; i++) chk($sformatf("rst_gate[%0d]", i), gate_out[i], 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // nominal: 0.5 + 1*1 + 1*2 + 1*(-1) = 2.5
        load_mem(32'h0000_8000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
        set_vec(32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000);
        run_op("nominal", 32'h0002_8000, 0, 1'b0);

        // backpressure with a stray start while DONE
        run_op("backpressure", 32'h0002_8000, 10, 1'b0);

        // inputs change right after the start edge
        set_vec(32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000);
        run_op("latching", 32'h0002_8000, 0, 1'b1);

`ifdef LSTM_GATE_SAT_EN
        ovf_exp = 32'h7FFF_FFFF;
`else
        ovf_exp = 32'h8000_FFFF;
`endif
        load_mem(32'h7FFF_FFFF, 32'h0001_0000, 32'h0, 32'h0);
        set_vec(32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000);
        run_op("overflow", ovf_exp, 0, 1'b0);

        // -0.5 LSB floors to -1
        load_mem(32'h0, 32'hFFFF_8000, 32'h0, 32'h0);
        set_vec(32'h0000_0001, 32'h0002_0000, 32'hFFFF_0000);
        run_op("rounding", 32'hFFFF_FFFF, 0, 1'b0);

        // reset mid-run, then a full nominal pass
        load_mem(32'h0000_8000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
        set_vec(32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 32'd0);
        chk("midrst_w_en", w_en, 32'd0);
        chk("midrst_out_valid", out_valid, 32'd0);
        for (int i = 0; i < ROWS; i++) chk($sformatf("midrst_gate[%0d]", i), gate_out[i], 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_op("after_reset", 32'h0002_8000, 0, 1'b0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
